// File: rtl/prim_fifo_sync_wm_pkg.sv
// prim_fifo_sync_wm_pkg: shared pointer/status types and sizing helper for prim_fifo_sync_wm.
package prim_fifo_sync_wm_pkg;
  localparam int PtrMaxW = 16;
  localparam int ShW = PtrMaxW + 1;
  typedef struct packed {
    logic phase;
    logic [PtrMaxW-1:0] val;
  } ptr_t;
  typedef struct packed {
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic [ShW-1:0] peak;
  } wm_status_t;
  function automatic int vbits(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prim_fifo_sync_wm_if.sv
// prim_fifo_sync_wm_if: write/read handshake bundle of prim_fifo_sync_wm.
interface prim_fifo_sync_wm_if #(parameter int Width = 16);
  logic wvalid_i, wready_o, rvalid_o, rready_i;
  logic [Width-1:0] wdata_i, rdata_o;
  modport master(output wvalid_i, wdata_i, rready_i, input wready_o, rvalid_o, rdata_o);
  modport slave(input wvalid_i, wdata_i, rready_i, output wready_o, rvalid_o, rdata_o);
endinterface

// File: rtl/prim_fifo_sync_wm_ptr.sv
// prim_fifo_sync_wm_ptr: wrapping FIFO pointer with phase bit, clear and increment.
module prim_fifo_sync_wm_ptr
  import prim_fifo_sync_wm_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output ptr_t ptr_o
);
  ptr_t ptr_q, ptr_d;
  logic wrap;
  assign wrap = ptr_q.val == PtrMaxW'(Depth - 1);
  assign ptr_d = !inc_i ? ptr_q :
                 wrap   ? {~ptr_q.phase, PtrMaxW'(0)} :
                          {ptr_q.phase, ptr_q.val + PtrMaxW'(1)};
  always_ff @(posedge clk_i) ptr_q <= (rst_i || clr_i) ? '0 : ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/prim_fifo_sync_wm.sv
// prim_fifo_sync_wm: sync FIFO with occupancy, watermarks, peak and sticky overflow;
// PRIM_FIFO_SYNC_WM_CNT_CHECK_EN adds a pointer-vs-counter consistency check on err_o.
module prim_fifo_sync_wm
  import prim_fifo_sync_wm_pkg::*;
#(
  parameter int Width = 16,
  parameter int Depth = 4,
  parameter bit Pass = 1'b1,
  parameter bit OutputZeroIfEmpty = 1'b1,
  localparam int DepthW = vbits(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  prim_fifo_sync_wm_if.slave   bus,
  input  logic [DepthW-1:0]    afull_thr_i,
  input  logic [DepthW-1:0]    aempty_thr_i,
  output logic                 full_o,
  output logic [DepthW-1:0]    depth_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 afull_evt_o,
  output logic [DepthW-1:0]    peak_depth_o,
  output logic                 overflow_o,
  output logic                 err_o
);
  localparam int PtrW = vbits(Depth);
  logic under_rst_q, under_rst, fifo_empty, empty, full, wr, rd, afull, almost_full_q, overflow_q;
  logic [DepthW-1:0] depth_q, depth_d, peak_q, peak_d;
  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] head;
  ptr_t wptr, rptr;
  wm_status_t st;
  logic unused_peak;

  always_ff @(posedge clk_i) under_rst_q <= rst_i;
  // rst_i is folded in combinationally so a mid-operation reset drops handshakes at once
  assign under_rst = under_rst_q | rst_i;
  assign full = (wptr.val == rptr.val) & (wptr.phase != rptr.phase);
  assign fifo_empty = wptr == rptr;
  assign empty = fifo_empty & ~(Pass && bus.wvalid_i);
  assign bus.wready_o = ~full & ~under_rst;
  assign bus.rvalid_o = ~empty & ~under_rst;
  assign wr = bus.wvalid_i & bus.wready_o & ~clr_i;
  assign rd = bus.rvalid_o & bus.rready_i & ~clr_i;

  prim_fifo_sync_wm_ptr #(.Depth(Depth)) u_wptr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(wr), .ptr_o(wptr)
  );
  prim_fifo_sync_wm_ptr #(.Depth(Depth)) u_rptr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(rd), .ptr_o(rptr)
  );

  always_ff @(posedge clk_i) if (wr) mem[wptr.val[PtrW-1:0]] <= bus.wdata_i;
  assign head = (Pass && fifo_empty) ? bus.wdata_i : mem[rptr.val[PtrW-1:0]];
  assign bus.rdata_o = (OutputZeroIfEmpty && !bus.rvalid_o) ? '0 : head;

  assign depth_d = (wr & ~rd) ? depth_q + 1'b1 : (rd & ~wr) ? depth_q - 1'b1 : depth_q;
  assign peak_d = (depth_d > peak_q) ? depth_d : peak_q;
  assign afull = (afull_thr_i != '0) && (depth_q >= afull_thr_i);

  always_ff @(posedge clk_i)
    if (rst_i || clr_i) begin
      depth_q <= '0;
      peak_q <= '0;
      almost_full_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      peak_q <= peak_d;
      almost_full_q <= afull;
      overflow_q <= overflow_q | (bus.wvalid_i & full & ~under_rst);
    end

  assign st.almost_full = afull;
  assign st.almost_empty = depth_q <= aempty_thr_i;
  assign st.overflow = overflow_q;
  assign st.peak = ShW'(peak_q);
  assign unused_peak = ^(st.peak >> DepthW);

  assign full_o = full;
  assign depth_o = depth_q;
  assign almost_full_o = st.almost_full;
  assign almost_empty_o = st.almost_empty;
  assign afull_evt_o = st.almost_full & ~almost_full_q;
  assign peak_depth_o = st.peak[DepthW-1:0];
  assign overflow_o = st.overflow;

`ifdef PRIM_FIFO_SYNC_WM_CNT_CHECK_EN
  logic [ShW-1:0] shadow;
  logic err_q;
  assign shadow = (wptr.phase == rptr.phase) ? {1'b0, wptr.val} - {1'b0, rptr.val}
                                             : {1'b0, wptr.val} + ShW'(Depth) - {1'b0, rptr.val};
  always_ff @(posedge clk_i) err_q <= (rst_i || clr_i) ? 1'b0 : err_q | (shadow != ShW'(depth_q));
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// tb_prim_fifo_sync_wm: directed vector table plus hand sequences for prim_fifo_sync_wm.
module tb_prim_fifo_sync_wm;
  logic clk = 1'b0, rst = 1'b1, clr_a = 1'b0, clr_b = 1'b0;
  always #5 clk = ~clk;

  prim_fifo_sync_wm_if #(.Width(16)) ba ();
  prim_fifo_sync_wm_if #(.Width(16)) bb ();
  logic [2:0] afthr_a = 3'd4, aethr_a = 3'd1, afthr_b = 3'd3, aethr_b = 3'd0;
  logic full_a, af_a, ae_a, evt_a, ovf_a, err_a, full_b, af_b, ae_b, evt_b, ovf_b, err_b;
  logic [2:0] depth_a, peak_a, depth_b, peak_b;

  prim_fifo_sync_wm #(.Width(16), .Depth(5), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) ua (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_a), .bus(ba), .afull_thr_i(afthr_a), .aempty_thr_i(aethr_a),
    .full_o(full_a), .depth_o(depth_a), .almost_full_o(af_a), .almost_empty_o(ae_a),
    .afull_evt_o(evt_a), .peak_depth_o(peak_a), .overflow_o(ovf_a), .err_o(err_a)
  );
  prim_fifo_sync_wm #(.Width(16), .Depth(4), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) ub (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_b), .bus(bb), .afull_thr_i(afthr_b), .aempty_thr_i(aethr_b),
    .full_o(full_b), .depth_o(depth_b), .almost_full_o(af_b), .almost_empty_o(ae_b),
    .afull_evt_o(evt_b), .peak_depth_o(peak_b), .overflow_o(ovf_b), .err_o(err_b)
  );

  typedef struct packed {
    logic wv; logic [15:0] wd; logic rr;
    logic [2:0] d; logic f; logic wrdy; logic rv; logic [15:0] rd; logic ov; logic af; logic ae;
  } vec_t;
  vec_t tv [14];
  int checks = 0, errors = 0, pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc_b(input logic wv, input logic [15:0] wd, input logic rr);
    bb.wvalid_i = wv; bb.wdata_i = wd; bb.rready_i = rr;
    @(posedge clk); #1;
    if (evt_b) pulses++;
    bb.wvalid_i = 1'b0; bb.rready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{'1, 16'h11, '0, 3'd1, '0, '1, '1, 16'h11, '0, '0, '1};
    tv[1]  = '{'1, 16'h22, '0, 3'd2, '0, '1, '1, 16'h11, '0, '0, '0};
    tv[2]  = '{'1, 16'h33, '0, 3'd3, '0, '1, '1, 16'h11, '0, '0, '0};
    tv[3]  = '{'1, 16'h44, '0, 3'd4, '0, '1, '1, 16'h11, '0, '1, '0};
    tv[4]  = '{'1, 16'h55, '0, 3'd5, '1, '0, '1, 16'h11, '0, '1, '0};
    tv[5]  = '{'1, 16'h66, '0, 3'd5, '1, '0, '1, 16'h11, '1, '1, '0};
    tv[6]  = '{'0, 16'h00, '1, 3'd4, '0, '1, '1, 16'h22, '1, '1, '0};
    tv[7]  = '{'0, 16'h00, '1, 3'd3, '0, '1, '1, 16'h33, '1, '0, '0};
    tv[8]  = '{'0, 16'h00, '1, 3'd2, '0, '1, '1, 16'h44, '1, '0, '0};
    tv[9]  = '{'0, 16'h00, '1, 3'd1, '0, '1, '1, 16'h55, '1, '0, '1};
    tv[10] = '{'0, 16'h00, '1, 3'd0, '0, '1, '0, 16'h00, '1, '0, '1};
    tv[11] = '{'1, 16'h77, '1, 3'd1, '0, '1, '1, 16'h77, '1, '0, '1};
    tv[12] = '{'1, 16'h88, '1, 3'd1, '0, '1, '1, 16'h88, '1, '0, '1};
    tv[13] = '{'0, 16'h00, '0, 3'd1, '0, '1, '1, 16'h88, '1, '0, '1};
    ba.wvalid_i = 1'b0; ba.wdata_i = '0; ba.rready_i = 1'b0;
    bb.wvalid_i = 1'b0; bb.wdata_i = '0; bb.rready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {ba.wready_o, ba.rvalid_o, ba.rdata_o, full_a, depth_a, peak_a, ovf_a, evt_a, err_a, af_a, ae_a},
        {1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("reset_b", {bb.wready_o, bb.rvalid_o, bb.rdata_o, full_b, depth_b, peak_b, ovf_b, evt_b, err_b, af_b, ae_b},
        {1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    #1;
    chk("wready_cycle1", {ba.wready_o, bb.wready_o}, 2'b00);
    @(posedge clk); #1;
    chk("wready_cycle2", {ba.wready_o, bb.wready_o}, 2'b11);

    for (int i = 0; i < 14; i++) begin
      ba.wvalid_i = tv[i].wv; ba.wdata_i = tv[i].wd; ba.rready_i = tv[i].rr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          {depth_a, full_a, ba.wready_o, ba.rvalid_o, ba.rdata_o, ovf_a, af_a, ae_a},
          {tv[i].d, tv[i].f, tv[i].wrdy, tv[i].rv, tv[i].rd, tv[i].ov, tv[i].af, tv[i].ae});
    end
    ba.wvalid_i = 1'b0; ba.rready_i = 1'b0;

    bb.wvalid_i = 1'b1; bb.wdata_i = 16'hA5; bb.rready_i = 1'b1;
    #1;
    chk("pass_rdata", {bb.rvalid_o, bb.rdata_o}, {1'b1, 16'hA5});
    @(posedge clk); #1;
    bb.wvalid_i = 1'b0; bb.rready_i = 1'b0;
    #1;
    chk("pass_depth", {depth_b, bb.rvalid_o, peak_b}, {3'd0, 1'b0, 3'd0});

    cyc_b(1'b1, 16'hB1, 1'b0);
    cyc_b(1'b1, 16'hB2, 1'b0);
    cyc_b(1'b1, 16'hB3, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b0);
    chk("evt_first", pulses, 1);
    chk("fill3_head", {depth_b, af_b, bb.rdata_o}, {3'd3, 1'b1, 16'hB1});
    cyc_b(1'b0, 16'h0, 1'b1);
    chk("drain2", {depth_b, af_b, bb.rdata_o}, {3'd2, 1'b0, 16'hB2});
    cyc_b(1'b1, 16'hB4, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b0);
    chk("evt_rearm", pulses, 2);
    chk("peak3", {peak_b, depth_b, af_b}, {3'd3, 3'd3, 1'b1});

    cyc_b(1'b1, 16'hB5, 1'b0);
    chk("full_b", {full_b, depth_b, bb.wready_o, peak_b}, {1'b1, 3'd4, 1'b0, 3'd4});
    cyc_b(1'b1, 16'hB6, 1'b0);
    chk("overflow_b", {ovf_b, depth_b}, {1'b1, 3'd4});
    clr_b = 1'b1; bb.wvalid_i = 1'b1; bb.wdata_i = 16'hEE;
    @(posedge clk); #1;
    clr_b = 1'b0; bb.wvalid_i = 1'b0;
    #1;
    chk("clr_full", {depth_b, ovf_b, peak_b, full_b, bb.rvalid_o, af_b},
        {3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    clr_b = 1'b1; bb.wvalid_i = 1'b1; bb.wdata_i = 16'h99;
    @(posedge clk); #1;
    clr_b = 1'b0; bb.wvalid_i = 1'b0;
    #1;
    chk("clr_discard", {depth_b, bb.rvalid_o, peak_b}, {3'd0, 1'b0, 3'd0});
    cyc_b(1'b1, 16'h42, 1'b0);
    chk("post_clr_write", {depth_b, bb.rvalid_o, bb.rdata_o}, {3'd1, 1'b1, 16'h42});

`ifdef PRIM_FIFO_SYNC_WM_CNT_CHECK_EN
    chk("err_clean", err_b, 1'b0);
    force ub.depth_q = 3'd0;
    @(posedge clk); #1;
    release ub.depth_q;
    chk("err_set", err_b, 1'b1);
    @(posedge clk); #1;
    chk("err_held", err_b, 1'b1);
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    chk("err_clr", err_b, 1'b0);
`endif

    ba.wvalid_i = 1'b1; ba.wdata_i = 16'h5A; ba.rready_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_drop", {ba.wready_o, ba.rvalid_o, bb.wready_o, bb.rvalid_o}, 4'b0000);
    @(posedge clk); #1;
    chk("rst_depth", {depth_a, ovf_a, peak_a, depth_b}, {3'd0, 1'b0, 3'd0, 3'd0});
    ba.wvalid_i = 1'b0; ba.rready_i = 1'b0;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prim_fifo_sync_wm.md
# prim_fifo_sync_wm

Synchronous single-clock FIFO with arbitrary depth, a registered occupancy counter, programmable almost-full/almost-empty watermarks, a peak-occupancy monitor and a sticky overflow flag. It is the next-generation buffer for OTBN-side and peripheral datapaths that must raise flow-control or interrupt events before the FIFO saturates, and it replaces ad-hoc depth comparators placed around plain FIFOs.

## Interface
- `Width`, 16: data width in bits, ≥1.
- `Depth`, 4: number of entries, ≥1, any value (power of two not required).
- `Pass`, 1'b1: when 1, a write into an empty FIFO is visible on the read port in the same cycle.
- `OutputZeroIfEmpty`, 1'b1: when 1, `rdata_o` is 0 whenever `rvalid_o` is 0.
- `DepthW` (localparam): `prim_util_pkg::vbits(Depth+1)`.
- `clk_i` in 1: clock; one clock domain, all logic on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `clr_i` in 1: synchronous flush.
- `wvalid_i` in 1, `wready_o` out 1, `wdata_i` in `Width`: write port.
- `rvalid_o` out 1, `rready_i` in 1, `rdata_o` out `Width`: read port.
- `afull_thr_i` in `DepthW`: almost-full threshold; 0 disables it.
- `aempty_thr_i` in `DepthW`: almost-empty threshold.
- `full_o` out 1, `depth_o` out `DepthW`: occupancy.
- `almost_full_o` out 1, `almost_empty_o` out 1: watermark levels.
- `afull_evt_o` out 1: single-cycle pulse on the rising edge of `almost_full_o`.
- `peak_depth_o` out `DepthW`: maximum `depth_o` since the last reset or clear.
- `overflow_o` out 1: sticky flag for a write attempted while full.
- `err_o` out 1: pointer/counter consistency error (see Configuration).

## Operation
- Pointers are `PtrW = vbits(Depth)` bits plus one phase bit. A pointer at `Depth-1` wraps to 0 and toggles its phase.
- `full` = values equal and phases differ. `fifo_empty` = both pointers equal.
- `depth_q` is a registered counter: +1 on a write only, −1 on a read only, unchanged when both or neither occur. `depth_o = depth_q`.
- `under_rst` is set by `rst_i` and cleared in the first cycle after reset. While it is set, `wready_o = rvalid_o = 0` and no pointer moves.
- `wready_o = ~full & ~under_rst`.
- `rvalid_o = ~empty & ~under_rst`, where `empty = fifo_empty & ~(Pass & wvalid_i)`.
- With `Pass`, when the FIFO is empty and `wvalid_i` is high, `rdata_o = wdata_i`. If that word is read in the same cycle, both pointers advance and `depth_q` stays 0.
- Watermark logic:
  - `almost_full_o = (afull_thr_i != 0) & (depth_q >= afull_thr_i)`.
  - `almost_empty_o = depth_q <= aempty_thr_i`.
  - `afull_evt_o = almost_full_o & ~almost_full_q`.
- `peak_q` updates to `depth_q` whenever `depth_q > peak_q`.
- `overflow_o` is set when `wvalid_i & full & ~under_rst`. It is held until `clr_i` or `rst_i`.
- Clear and reset priority:
  - `clr_i` zeroes the pointers, `depth_q`, `peak_q`, `overflow_o`, `almost_full_q` and the sticky error. Storage contents are not cleared.
  - `clr_i` wins over a write or read in the same cycle; that transfer is discarded.
  - `rst_i` wins over `clr_i`.
- Thresholds above `Depth` are legal: an almost-full threshold above `Depth` never asserts, and an almost-empty threshold at or above `Depth` is always asserted.

## Timing
- Reset values:
  - 0 for `wready_o`, `rvalid_o`, `rdata_o` (with zero-if-empty), `full_o`, `depth_o`, `peak_depth_o`, `overflow_o`, `afull_evt_o` and `err_o`.
  - `almost_full_o` is 0.
  - `almost_empty_o` is 1.
- `wready_o` rises in the second cycle after `rst_i` is sampled low.
- Write-to-read latency is 1 cycle with `Pass=0`, or with `Pass=1` when the FIFO is not empty. It is 0 cycles with `Pass=1` into an empty FIFO.
- `depth_o`, `full_o`, the watermarks and `peak_depth_o` reflect a transfer in the cycle after the handshake.
- `afull_evt_o` lasts exactly one cycle. It re-arms only after `almost_full_o` deasserts.
- A reset asserted mid-operation drops all handshakes in that same cycle.

## Configuration
- `PRIM_FIFO_SYNC_WM_CNT_CHECK_EN`:
  - Defined: a shadow depth is derived from the pointer difference, including phase, and compared with `depth_q` every cycle. A mismatch sets `err_o`, which stays set until `clr_i` or `rst_i`.
  - Undefined: the shadow logic is absent and `err_o` is tied to 0.

## Structure
- `prim_fifo_sync_wm_pkg` holds a `ptr_t` struct (phase bit plus value) and a `wm_status_t` struct (almost_full, almost_empty, overflow, peak).
- Sub-module `prim_fifo_sync_wm_ptr` contains one wrapping pointer with phase, clear and increment. It is instantiated once for the write pointer and once for the read pointer.

## Test plan
- Reset → all outputs at their reset values; `wready_o=0` in the first cycle after reset, 1 in the second.
- `Depth=5`, `Pass=0`: write 5 words (`0x11`..`0x55`) → `full_o=1`, `depth_o=5`. A sixth write sets `overflow_o`. Read 5 words → `0x11`..`0x55` in order, pointers wrap.
- `Pass=1`, FIFO empty, `wvalid_i=rready_i=1` with `wdata_i=0xA5` → `rdata_o=0xA5` in the same cycle and `depth_o` stays 0.
- `afull_thr_i=3`, fill to 3 → `afull_evt_o` pulses once. Drain to 2 then refill to 3 → a second pulse. `peak_depth_o` reads 3.
- `clr_i` together with `wvalid_i` at `depth_o=4` → next cycle `depth_o=0`, `overflow_o=0`, `peak_depth_o=0`, and the word is discarded.
- With the check macro defined, force the `depth_q` bit flip → `err_o=1` next cycle and held until `clr_i`.
